// File: rtl/regfile_mp_pkg.sv
// Shared constants and the pending-write record for the multi-port register file.
// The record is sized for the widest supported configuration; unused upper bits stay zero.
package regfile_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NRD    = 2;
    localparam int PEND_AW_MAX = 16;
    localparam int PEND_W_MAX  = 64;

    typedef struct packed {
        logic                   valid;
        logic [PEND_AW_MAX-1:0] addr;
        logic [PEND_W_MAX-1:0]  data;
    } pend_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Write/stall/read bus of the register file; the requester owns the master side.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD
);
    localparam int AW = $clog2(DEPTH);

    logic                 WRITE;
    logic [AW-1:0]        INADDRESS;
    logic [WIDTH-1:0]     IN;
    logic                 BUSY;
    logic [NRD*AW-1:0]    RADDR;
    logic [NRD*WIDTH-1:0] RDATA;
    logic                 PEND_VALID;
    logic                 OVERRUN;

    modport master (
        output WRITE, INADDRESS, IN, BUSY, RADDR,
        input  RDATA, PEND_VALID, OVERRUN
    );

    modport slave (
        input  WRITE, INADDRESS, IN, BUSY, RADDR,
        output RDATA, PEND_VALID, OVERRUN
    );
endinterface

// File: rtl/regfile_mp_pend.sv
// One-entry deferred-write buffer: captures writes during a stall, merges same-address
// writes, flags dropped writes, and tells the array what to commit at each edge.
module regfile_pend
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             write_i,
    input  logic             busy_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             pend_valid_o,
    output logic [AW-1:0]    held_addr_o,
    output logic [WIDTH-1:0] held_data_o,
    output logic             flush_o,
    output logic             commit_new_o,
    output logic             overrun_o
);
    pend_t pend_q, pend_d;
    logic  ovr_q, ovr_d;
    logic  wr_ok;

    // Writes to r0 vanish entirely when r0 is hardwired, so they can never overrun.
    assign wr_ok = write_i && !((ZERO_R0 != 0) && (addr_i == '0));

    always_comb begin
        pend_d       = pend_q;
        ovr_d        = ovr_q;
        flush_o      = 1'b0;
        commit_new_o = 1'b0;
        if (pend_q.valid) begin
            if (busy_i) begin
                if (wr_ok) begin
                    if (addr_i == pend_q.addr[AW-1:0]) begin
                        pend_d.data             = '0;
                        pend_d.data[WIDTH-1:0]  = data_i;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end else begin
                flush_o      = 1'b1;
                commit_new_o = wr_ok;
                pend_d       = '0;
            end
        end else if (wr_ok) begin
            if (busy_i) begin
                pend_d                  = '0;
                pend_d.valid            = 1'b1;
                pend_d.addr[AW-1:0]     = addr_i;
                pend_d.data[WIDTH-1:0]  = data_i;
            end else begin
                commit_new_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign pend_valid_o = pend_q.valid;
    assign held_addr_o  = pend_q.addr[AW-1:0];
    assign held_data_o  = pend_q.data[WIDTH-1:0];
    assign overrun_o    = ovr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a one-entry stall buffer in front of the array.
// Reads are combinational and see the held entry, but never the in-flight write data.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NRD     = DEF_NRD,
    parameter int ZERO_R0 = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pend_valid;
    logic [AW-1:0]    held_addr;
    logic [WIDTH-1:0] held_data;
    logic             flush;
    logic             commit_new;
    logic             overrun;

    regfile_pend #(
        .WIDTH   (WIDTH),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_pend (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .write_i      (bus.WRITE),
        .busy_i       (bus.BUSY),
        .addr_i       (bus.INADDRESS),
        .data_i       (bus.IN),
        .pend_valid_o (pend_valid),
        .held_addr_o  (held_addr),
        .held_data_o  (held_data),
        .flush_o      (flush),
        .commit_new_o (commit_new),
        .overrun_o    (overrun)
    );

    // The new write is applied after the flush so it wins on an equal address.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (flush)      mem_q[held_addr]     <= held_data;
            if (commit_new) mem_q[bus.INADDRESS] <= bus.IN;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;

        assign ra = bus.RADDR[k*AW +: AW];

        always_comb begin
            rd = mem_q[ra];
            if (pend_valid && (ra == held_addr)) rd = held_data;
            if ((ZERO_R0 != 0) && (ra == '0))    rd = '0;
        end

        assign bus.RDATA[k*WIDTH +: WIDTH] = rd;
    end

    assign bus.PEND_VALID = pend_valid;
    assign bus.OVERRUN    = overrun;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios then random traffic, two instances
// (r0 writable and r0 hardwired) compared against a behavioural model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int N  = 2;
    localparam int AW = 3;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NRD(N)) bus0 ();
    regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NRD(N)) bus1 ();

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_R0(0)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus0.slave)
    );

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_R0(1)) dut_z (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus1.slave)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: index 0 is the plain instance, index 1 the hardwired-r0 one.
    logic [W-1:0]  m_mem [2][D];
    logic          m_pv  [2];
    logic [AW-1:0] m_pa  [2];
    logic [W-1:0]  m_pd  [2];
    logic          m_ovr [2];

    logic          cw, cb;
    logic [AW-1:0] ca;
    logic [W-1:0]  cd;
    logic [AW-1:0] ra0, ra1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_read(input int z, input logic [AW-1:0] a);
        if (z == 1 && a == 0) return '0;
        if (m_pv[z] && m_pa[z] == a) return m_pd[z];
        return m_mem[z][a];
    endfunction

    function automatic void m_clear();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < D; i++) m_mem[z][i] = '0;
            m_pv[z]  = 1'b0;
            m_pa[z]  = '0;
            m_pd[z]  = '0;
            m_ovr[z] = 1'b0;
        end
    endfunction

    function automatic void m_step(input int z);
        logic ok;
        ok = cw && !(z == 1 && ca == 0);
        if (!cb) begin
            if (m_pv[z]) m_mem[z][m_pa[z]] = m_pd[z];
            m_pv[z] = 1'b0;
            if (ok) m_mem[z][ca] = cd;
        end else if (ok) begin
            if (!m_pv[z]) begin
                m_pv[z] = 1'b1;
                m_pa[z] = ca;
                m_pd[z] = cd;
            end else if (m_pa[z] == ca) begin
                m_pd[z] = cd;
            end else begin
                m_ovr[z] = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic w, input logic b, input logic [AW-1:0] a, input logic [W-1:0] d);
        cw = w; cb = b; ca = a; cd = d;
        bus0.WRITE = w; bus0.BUSY = b; bus0.INADDRESS = a; bus0.IN = d;
        bus1.WRITE = w; bus1.BUSY = b; bus1.INADDRESS = a; bus1.IN = d;
    endtask

    task automatic setrd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra0 = a0; ra1 = a1;
        bus0.RADDR = {a1, a0};
        bus1.RADDR = {a1, a0};
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        if (!RESET) begin
            m_step(0);
            m_step(1);
        end
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".p0.rd0"}, 32'(bus0.RDATA[W-1:0]),   32'(m_read(0, ra0)));
        chk({tag, ".p0.rd1"}, 32'(bus0.RDATA[2*W-1:W]), 32'(m_read(0, ra1)));
        chk({tag, ".p0.pv"},  32'(bus0.PEND_VALID),     32'(m_pv[0]));
        chk({tag, ".p0.ovr"}, 32'(bus0.OVERRUN),        32'(m_ovr[0]));
        chk({tag, ".p1.rd0"}, 32'(bus1.RDATA[W-1:0]),   32'(m_read(1, ra0)));
        chk({tag, ".p1.rd1"}, 32'(bus1.RDATA[2*W-1:W]), 32'(m_read(1, ra1)));
        chk({tag, ".p1.pv"},  32'(bus1.PEND_VALID),     32'(m_pv[1]));
        chk({tag, ".p1.ovr"}, 32'(bus1.OVERRUN),        32'(m_ovr[1]));
    endtask

    // Reset is asserted mid-cycle with write/stall active, held across an edge, released on negedge.
    task automatic do_reset();
        RESET = 1'b1;
        drive(1'b1, 1'b1, 3'($urandom), 8'($urandom));
        m_clear();
        #1;
        check_state("rst_async");
        @(posedge CLK);
        #1;
        check_state("rst_edge");
        @(negedge CLK);
        RESET = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        ra0 = '0; ra1 = '0;
        bus0.RADDR = '0; bus1.RADDR = '0;
        m_clear();
        @(negedge CLK);
        do_reset();

        // basic write/read, and no forwarding of in-flight data
        setrd(3'd3, 3'd4);
        drive(1'b1, 1'b0, 3'd3, 8'h5A);
        #1;
        chk("basic_pre_edge", 32'(bus0.RDATA[W-1:0]), 32'h00);
        step();
        drive(1'b0, 1'b0, '0, '0);
        setrd(3'd3, 3'd4);
        chk("basic_rd0", 32'(bus0.RDATA[W-1:0]), 32'h5A);
        chk("basic_rd1", 32'(bus0.RDATA[2*W-1:W]), 32'h00);
        check_state("basic");

        // deferred write and forwarding
        drive(1'b1, 1'b1, 3'd2, 8'h11);
        step();
        drive(1'b0, 1'b0, '0, '0);
        setrd(3'd2, 3'd3);
        chk("defer_pv", 32'(bus0.PEND_VALID), 32'd1);
        chk("defer_fwd", 32'(bus0.RDATA[W-1:0]), 32'h11);
        check_state("defer_held");
        step();
        chk("defer_pv_clr", 32'(bus0.PEND_VALID), 32'd0);
        chk("defer_commit", 32'(bus0.RDATA[W-1:0]), 32'h11);
        check_state("defer_done");

        // latest wins
        drive(1'b1, 1'b1, 3'd5, 8'h01);
        step();
        drive(1'b1, 1'b1, 3'd5, 8'h02);
        step();
        drive(1'b0, 1'b0, '0, '0);
        setrd(3'd5, 3'd0);
        chk("latest_held", 32'(bus0.RDATA[W-1:0]), 32'h02);
        step();
        setrd(3'd5, 3'd0);
        chk("latest_commit", 32'(bus0.RDATA[W-1:0]), 32'h02);
        chk("latest_no_ovr", 32'(bus0.OVERRUN), 32'd0);
        check_state("latest");

        // overrun
        drive(1'b1, 1'b1, 3'd1, 8'hAA);
        step();
        drive(1'b1, 1'b1, 3'd6, 8'hBB);
        step();
        drive(1'b0, 1'b1, '0, '0);
        setrd(3'd6, 3'd1);
        chk("ovr_set", 32'(bus0.OVERRUN), 32'd1);
        chk("ovr_r6", 32'(bus0.RDATA[W-1:0]), 32'h00);
        check_state("ovr_held");
        drive(1'b0, 1'b0, '0, '0);
        step();
        chk("ovr_r1", 32'(bus0.RDATA[2*W-1:W]), 32'hAA);
        chk("ovr_r6_after", 32'(bus0.RDATA[W-1:0]), 32'h00);
        for (int i = 0; i < 3; i++) step();
        chk("ovr_sticky", 32'(bus0.OVERRUN), 32'd1);
        check_state("ovr_done");

        // simultaneous commit, same and different address
        drive(1'b1, 1'b1, 3'd7, 8'h10);
        step();
        drive(1'b1, 1'b0, 3'd7, 8'h20);
        step();
        drive(1'b0, 1'b0, '0, '0);
        setrd(3'd7, 3'd0);
        chk("simul_same", 32'(bus0.RDATA[W-1:0]), 32'h20);
        drive(1'b1, 1'b1, 3'd7, 8'h10);
        step();
        drive(1'b1, 1'b0, 3'd0, 8'h30);
        step();
        drive(1'b0, 1'b0, '0, '0);
        setrd(3'd7, 3'd0);
        chk("simul_diff_r7", 32'(bus0.RDATA[W-1:0]), 32'h10);
        chk("simul_diff_r0", 32'(bus0.RDATA[2*W-1:W]), 32'h30);
        check_state("simul");

        // reset mid-stall discards the held entry
        drive(1'b1, 1'b1, 3'd4, 8'h44);
        step();
        setrd(3'd4, 3'd0);
        chk("midstall_pv", 32'(bus0.PEND_VALID), 32'd1);
        do_reset();
        step();
        setrd(3'd4, 3'd0);
        chk("midstall_pv_clr", 32'(bus0.PEND_VALID), 32'd0);
        chk("midstall_r4", 32'(bus0.RDATA[W-1:0]), 32'h00);
        check_state("midstall");

        // hardwired r0
        drive(1'b1, 1'b0, 3'd0, 8'hFF);
        step();
        drive(1'b1, 1'b1, 3'd0, 8'hFF);
        setrd(3'd0, 3'd0);
        chk("zr0_rd", 32'(bus1.RDATA[W-1:0]), 32'h00);
        step();
        drive(1'b0, 1'b0, '0, '0);
        setrd(3'd0, 3'd1);
        chk("zr0_no_pend", 32'(bus1.PEND_VALID), 32'd0);
        chk("zr0_rd_busy", 32'(bus1.RDATA[W-1:0]), 32'h00);
        check_state("zr0");
        step();
        check_state("zr0_done");

        // random traffic
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                @(negedge CLK);
                do_reset();
            end
            drive(1'($urandom), ($urandom_range(0, 99) < 45),
                  3'($urandom), 8'($urandom));
            setrd(3'($urandom), 3'($urandom));
            check_state("rnd_pre");
            step();
            setrd(3'($urandom), 3'($urandom));
            check_state("rnd_post");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
